// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit.
// Holds the architectural HI/LO pair. mult/multu/div/divu results are computed
// at the start edge into shadow registers and committed after a fixed busy period.
// mthi/mtlo write HI/LO directly, with no busy period.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  E_MDU_op,
    input  logic        E_MDU_sel,
    input  logic [31:0] E_rs_data,
    input  logic [31:0] E_rt_data,
    output logic [31:0] E_HI_LO,
    output logic        start,
    output logic        busy
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [31:0] hi, lo;
    logic [31:0] hi_n, lo_n;
    logic [3:0]  cnt;

    logic signed [63:0] a_ext, b_ext, mul_s;
    logic        [63:0] mul_u;
    logic        [31:0] hi_calc, lo_calc;

    // Signed divide via magnitudes: quotient truncates toward zero, remainder
    // takes the dividend's sign. Working on magnitudes also makes
    // 0x80000000 / -1 wrap to 0x80000000 with remainder 0 instead of overflowing.
    function automatic logic [63:0] sdiv(input logic [31:0] n, input logic [31:0] d);
        logic [31:0] n_mag, d_mag, q_mag, r_mag, quot, rem;
        n_mag = n[31] ? (~n + 32'd1) : n;
        d_mag = d[31] ? (~d + 32'd1) : d;
        q_mag = n_mag / d_mag;
        r_mag = n_mag % d_mag;
        quot  = (n[31] ^ d[31]) ? (~q_mag + 32'd1) : q_mag;
        rem   = n[31] ? (~r_mag + 32'd1) : r_mag;
        return {rem, quot};
    endfunction

    // Unsigned divide: remainder in the upper half, quotient in the lower half.
    function automatic logic [63:0] udiv(input logic [31:0] n, input logic [31:0] d);
        return {n % d, n / d};
    endfunction

    assign a_ext = {{32{E_rs_data[31]}}, E_rs_data};
    assign b_ext = {{32{E_rt_data[31]}}, E_rt_data};
    assign mul_s = a_ext * b_ext;
    assign mul_u = {32'd0, E_rs_data} * {32'd0, E_rt_data};

    // Result selection; a zero divisor keeps the committed HI/LO so the commit is a no-op.
    always_comb begin
        hi_calc = hi;
        lo_calc = lo;
        case (E_MDU_op)
            OP_MULT:  {hi_calc, lo_calc} = mul_s;
            OP_MULTU: {hi_calc, lo_calc} = mul_u;
            OP_DIV:   if (E_rt_data != 32'd0) {hi_calc, lo_calc} = sdiv(E_rs_data, E_rt_data);
            OP_DIVU:  if (E_rt_data != 32'd0) {hi_calc, lo_calc} = udiv(E_rs_data, E_rt_data);
            default: ;
        endcase
    end

    assign start   = (E_MDU_op >= OP_MULT) && (E_MDU_op <= OP_DIVU) && !busy && !req;
    assign E_HI_LO = E_MDU_sel ? hi : lo;

    // IDLE/RUN control: launch, count down, commit shadow into HI/LO; mthi/mtlo only in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= 4'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            hi_n  <= 32'd0;
            lo_n  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!req) begin
                        case (E_MDU_op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                hi_n  <= hi_calc;
                                lo_n  <= lo_calc;
                                cnt   <= (E_MDU_op <= OP_MULTU) ? MULT_CNT : DIV_CNT;
                                busy  <= 1'b1;
                                state <= RUN;
                            end
                            OP_MTHI: hi <= E_rs_data;
                            OP_MTLO: lo <= E_rs_data;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (cnt > 4'd1) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        hi    <= hi_n;
                        lo    <= lo_n;
                        cnt   <= 4'd0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed bench for e_mdu with a cycle-level reference model and
// hand-computed literal checks.
module tb_e_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [2:0]  E_MDU_op = 3'd0;
    logic        E_MDU_sel = 1'b0;
    logic [31:0] E_rs_data = 32'd0;
    logic [31:0] E_rt_data = 32'd0;
    logic [31:0] E_HI_LO;
    logic        start;
    logic        busy;

    int total = 0;
    int bad = 0;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .req(req), .E_MDU_op(E_MDU_op), .E_MDU_sel(E_MDU_sel),
        .E_rs_data(E_rs_data), .E_rt_data(E_rt_data), .E_HI_LO(E_HI_LO),
        .start(start), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
    bit          m_run = 1'b0;
    longint      edge_n = 0;
    longint      commit_edge = 0;

    function automatic logic [63:0] calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] hi, input logic [31:0] lo);
        longint sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r = {hi, lo};
        case (op)
            3'd1: r = sa * sb;
            3'd2: r = ua * ub;
            3'd3: if (b != 0) begin
                sq = sa / sb;
                sr = sa % sb;
                r = {sr[31:0], sq[31:0]};
            end
            3'd4: if (b != 0) begin
                uq = ua / ub;
                ur = ua % ub;
                r = {ur[31:0], uq[31:0]};
            end
            default: ;
        endcase
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        bit was_busy;
        if (reset) begin
            m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; m_run = 0;
        end else begin
            edge_n++;
            was_busy = m_run;
            if (m_run && edge_n == commit_edge) begin
                m_hi = p_hi;
                m_lo = p_lo;
                m_run = 0;
            end
            if (!was_busy && !req) begin
                if (E_MDU_op >= 3'd1 && E_MDU_op <= 3'd4) begin
                    {p_hi, p_lo} = calc(E_MDU_op, E_rs_data, E_rt_data, m_hi, m_lo);
                    m_run = 1;
                    commit_edge = edge_n + ((E_MDU_op <= 3'd2) ? MC : DC);
                end else if (E_MDU_op == 3'd5) begin
                    m_hi = E_rs_data;
                end else if (E_MDU_op == 3'd6) begin
                    m_lo = E_rs_data;
                end
            end
        end
    end

    // Compare DUT outputs against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        logic [31:0] exp_rd;
        bit exp_start;
        exp_rd = E_MDU_sel ? m_hi : m_lo;
        exp_start = (E_MDU_op >= 3'd1) && (E_MDU_op <= 3'd4) && !m_run && !req && !reset;
        total++;
        if (busy !== m_run) begin
            bad++;
            $display("FAIL model_busy t=%0t actual=%0b required=%0b", $time, busy, m_run);
        end
        total++;
        if (E_HI_LO !== exp_rd) begin
            bad++;
            $display("FAIL model_hilo t=%0t actual=%08h required=%08h", $time, E_HI_LO, exp_rd);
        end
        if (!reset) begin
            total++;
            if (start !== exp_start) begin
                bad++;
                $display("FAIL model_start t=%0t actual=%0b required=%0b", $time, start, exp_start);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic sel, input string name, input logic [31:0] exp);
        E_MDU_sel = sel;
        #1;
        chk(name, E_HI_LO, exp);
    endtask

    // Present an op for one cycle; checks the combinational start first.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic r, input logic exp_start, input string name);
        E_MDU_op = op; E_rs_data = a; E_rt_data = b; req = r;
        #1;
        chk(name, {31'd0, start}, {31'd0, exp_start});
        step(1);
        E_MDU_op = 3'd0; req = 1'b0;
    endtask

    // Count remaining busy cycles (called in the cycle after the start edge).
    task automatic busy_len(input string name, input int exp);
        int n;
        n = 0;
        while (busy && n < 40) begin
            n++;
            step(1);
        end
        chk(name, n, exp);
    endtask

    initial begin
        step(3);
        reset = 1'b0;
        step(1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rd(1'b1, "reset_hi", 32'd0);
        rd(1'b0, "reset_lo", 32'd0);

        // op 7 behaves as none
        E_MDU_op = 3'd7; #1;
        chk("op7_start", {31'd0, start}, 32'd0);
        E_MDU_op = 3'd0;
        step(1);

        // mult -3 * 5
        issue(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b1, "mult_start");
        rd(1'b1, "mult_hi_during_busy", 32'd0);
        busy_len("mult_busy_len", 5);
        rd(1'b1, "mult_hi", 32'hFFFF_FFFF);
        rd(1'b0, "mult_lo", 32'hFFFF_FFF1);
        step(1);

        // divu 7/2
        issue(3'd4, 32'd7, 32'd2, 1'b0, 1'b1, "divu_start");
        busy_len("divu_busy_len", 10);
        rd(1'b0, "divu_lo", 32'd3);
        rd(1'b1, "divu_hi", 32'd1);
        step(1);

        // div -7/2
        issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, "div_start");
        busy_len("div_busy_len", 10);
        rd(1'b0, "div_lo", 32'hFFFF_FFFD);
        rd(1'b1, "div_hi", 32'hFFFF_FFFF);
        step(1);

        // div overflow case
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, "divovf_start");
        busy_len("divovf_busy_len", 10);
        rd(1'b0, "divovf_lo", 32'h8000_0000);
        rd(1'b1, "divovf_hi", 32'd0);
        step(1);

        // req blocks mult and mtlo
        issue(3'd1, 32'd3, 32'd4, 1'b1, 1'b0, "req_mult_start");
        chk("req_mult_busy", {31'd0, busy}, 32'd0);
        rd(1'b0, "req_mult_lo", 32'h8000_0000);
        issue(3'd6, 32'h0000_DEAD, 32'd0, 1'b1, 1'b0, "req_mtlo_start");
        rd(1'b0, "req_mtlo_lo", 32'h8000_0000);
        issue(3'd6, 32'h0000_DEAD, 32'd0, 1'b0, 1'b0, "mtlo_start");
        rd(1'b0, "mtlo_lo", 32'h0000_DEAD);
        issue(3'd1, 32'd3, 32'd4, 1'b0, 1'b1, "mult_again_start");
        busy_len("mult_again_len", 5);
        rd(1'b0, "mult_again_lo", 32'd12);
        rd(1'b1, "mult_again_hi", 32'd0);
        step(1);

        // mthi during busy is ignored
        issue(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1, "multu_start");
        step(1);
        issue(3'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0, "mthi_busy_start");
        busy_len("multu_len", 3);
        rd(1'b1, "multu_hi", 32'd1);
        rd(1'b0, "multu_lo", 32'hFFFF_FFFE);
        issue(3'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0, "mthi_start");
        rd(1'b1, "mthi_hi", 32'h1234_5678);
        step(1);

        // divu by zero preserves HI/LO
        issue(3'd5, 32'h0000_000A, 32'd0, 1'b0, 1'b0, "mthi_a");
        issue(3'd6, 32'h0000_000B, 32'd0, 1'b0, 1'b0, "mtlo_b");
        issue(3'd4, 32'd5, 32'd0, 1'b0, 1'b1, "divz_start");
        busy_len("divz_len", 10);
        rd(1'b1, "divz_hi", 32'h0000_000A);
        rd(1'b0, "divz_lo", 32'h0000_000B);
        step(1);

        // async reset in cycle 3 of a div
        issue(3'd3, 32'd100, 32'd7, 1'b0, 1'b1, "rstrun_start");
        step(2);
        reset = 1'b1;
        #1;
        chk("rstrun_busy", {31'd0, busy}, 32'd0);
        rd(1'b1, "rstrun_hi", 32'd0);
        rd(1'b0, "rstrun_lo", 32'd0);
        step(2);
        reset = 1'b0;
        step(15);
        chk("rstrun_busy_after", {31'd0, busy}, 32'd0);
        rd(1'b1, "rstrun_hi_after", 32'd0);
        rd(1'b0, "rstrun_lo_after", 32'd0);
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit for the P7 pipeline. It accepts mult/multu/div/divu/mthi/mtlo operations from the instruction currently in E and models the fixed multi-cycle latency with a busy counter. It holds the architectural HI/LO registers and supplies the mfhi/mflo value that the E/M pipeline register captures as `E_HI_LO`. The hazard unit uses `busy` and `start` to stall D-stage instructions that touch the MDU.

## Interface
- `MULT_CYCLES`, default 5: busy duration for mult/multu; legal range 1..15.
- `DIV_CYCLES`, default 10: busy duration for div/divu; legal range 1..15.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  exception/interrupt taken this cycle. Suppresses every E-stage MDU side effect.
- `E_MDU_op`  in  3  operation encoding:
  - 0 none
  - 1 mult
  - 2 multu
  - 3 div
  - 4 divu
  - 5 mthi
  - 6 mtlo
  - 7 treated as none
- `E_MDU_sel`  in  1  read select: 1 = HI, 0 = LO.
- `E_rs_data`  in  32  operand A / mthi-mtlo source.
- `E_rt_data`  in  32  operand B.
- `E_HI_LO`  out  32  combinational; `E_MDU_sel ? HI : LO` from committed registers.
- `start`  out  1  combinational; 1 when the op is 1..4, `busy`=0 and `req`=0.
- `busy`  out  1  registered; 1 while a multiply/divide is in flight.

## Operation
- State: committed `HI`/`LO` (32 each), shadow `hi_n`/`lo_n` (32 each), `cnt` (4 bits), `busy`. Two states:
  - IDLE (`busy`=0)
  - RUN (`busy`=1)
- IDLE, `start`=1 at an edge:
  - Compute the result from `E_rs_data`/`E_rt_data` into the shadow registers.
  - Set `cnt` to `MULT_CYCLES` or `DIV_CYCLES`, set `busy`=1, enter RUN.
- RUN, each edge:
  - If `cnt`>1: `cnt`--.
  - If `cnt`==1: `HI`<=`hi_n`, `LO`<=`lo_n`, `cnt`<=0, `busy`<=0, return to IDLE.
- Arithmetic:
  - mult: 64-bit signed product; HI = upper 32 bits, LO = lower 32 bits.
  - multu: same, unsigned.
  - div: quotient truncated toward zero into LO; remainder into HI, with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned quotient into LO, remainder into HI.
- Divide by zero (div/divu with `E_rt_data`=0):
  - The full `DIV_CYCLES` busy period still occurs.
  - The shadow registers are loaded from the current HI/LO, so HI/LO are unchanged at commit.
- mthi/mtlo: in IDLE with `req`=0, write `E_rs_data` to HI/LO at the edge. No busy period.
- Any op 1..6 arriving while `busy`=1 is ignored: no state change. The hazard unit must keep such ops out of E; ignoring them is the required defined behaviour if one arrives anyway.
- `req`=1 blocks start, mthi and mtlo at that edge. An operation already in RUN is unaffected and commits normally: it belongs to an instruction already past E.
- `E_HI_LO` reflects only committed HI/LO. Shadow values are never visible.

## Timing
- Reset (asynchronous, takes effect immediately): HI=0, LO=0, shadow=0, `cnt`=0, `busy`=0. `E_HI_LO`=0 while reset is asserted. Reset during RUN abandons the operation: no commit.
- Start edge at the end of cycle t:
  - `busy`=1 in cycles t+1 .. t+N, where N is the op's latency parameter.
  - HI/LO are updated at the end of cycle t+N and readable from cycle t+N+1.
- A new `start` is legal at the end of cycle t+N+1 at the earliest; `busy`=0 in that cycle.
- mthi/mtlo at the end of cycle t: the new value appears on `E_HI_LO` in cycle t+1.
- `start` is purely combinational on the current op, `busy` and `req`. It has no registered delay.
- When the commit edge and an ignored op coincide, the commit wins and the op is still ignored.

## Test plan
- mult, A=0xFFFFFFFD (−3), B=5:
  - `busy`=1 for exactly 5 cycles.
  - From cycle t+6: HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - HI/LO read 0 (the reset value) during busy.
- divu 7/2 then div 0xFFFFFFF9/2:
  - divu: LO=3, HI=1 after 10 busy cycles.
  - div: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - div 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- `req`=1 in the same cycle as a mult or mtlo op:
  - `start`=0, `busy` stays 0, HI/LO unchanged.
  - The same op repeated with `req`=0 executes normally.
- mthi 0x12345678 issued during a mult busy period:
  - The mthi is ignored; HI after commit equals the product.
  - mthi after `busy` falls: HI=0x12345678 on the next cycle.
- divu by zero with HI=0xA, LO=0xB: `busy` for 10 cycles, then HI=0xA, LO=0xB.
- Reset asserted asynchronously mid-RUN (cycle 3 of a div):
  - `busy`=0 and HI=LO=0 immediately.
  - No commit occurs after reset is released.
